// File: rtl/clock_group_pkg.sv
// ---------------------------------------------------------------------------
// clock_group_pkg
// Shared definitions for the clock-group blocks: the reset-sink sequencing
// state enum, the default parameter values and a small helper that sizes the
// sink's cycle counter.
// ---------------------------------------------------------------------------
package clock_group_pkg;

   // Default parameter set for a clock-group member sink
   localparam int DEF_NUM_MEMBERS = 6;
   localparam int DEF_SYNC_STAGES = 3;
   localparam int DEF_STRETCH     = 16;
   localparam int DEF_STAGGER     = 4;

   // Reset-sink sequencing states
   typedef enum logic [2:0] {
      ST_SYNC,
      ST_STRETCH,
      ST_RELEASE,
      ST_RUN,
      ST_SW_HOLD,
      ST_SW_WAIT
   } sink_state_t;

   // The counter has to reach the larger of the stretch and stagger limits.
   // A one-bit floor keeps the counter a real signal when both are 1.
   function automatic int cnt_width(input int stretch, input int stagger);
      int largest;
      largest = (stretch > stagger) ? stretch : stagger;
      return (largest > 1) ? $clog2(largest) : 1;
   endfunction

endpackage

// File: rtl/reset_synchronizer.sv
// ---------------------------------------------------------------------------
// reset_synchronizer
// Catches an asynchronous active-high reset and produces a version that is
// asserted immediately but released only on a clock edge, after STAGES flops.
//
// Ports:
//   clock    - destination clock
//   reset    - raw asynchronous active-high reset
//   sync_rst - synchronized reset, high while the chain still holds a 1
// ---------------------------------------------------------------------------
module reset_synchronizer #(
   parameter int STAGES = 3
) (
   input  logic clock,
   input  logic reset,
   output logic sync_rst
);

   logic [STAGES-1:0] chain;

   // Every stage is forced high by the raw reset; once it drops, zeros ripple
   // through so the last stage falls only after STAGES clean edges.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         chain <= '1;
      end else begin
         chain <= {chain[STAGES-2:0], 1'b0};
      end
   end

   assign sync_rst = chain[STAGES-1];

endmodule

// File: rtl/clock_group_reset_sink.sv
// ---------------------------------------------------------------------------
// clock_group_reset_sink
// Receiving end of a clock-group member. Turns the raw group reset into a set
// of per-domain resets that are asserted together and asynchronously, then
// released one after another in ascending order once the synchronized reset
// has been stable for STRETCH cycles. A four-phase request/acknowledge pair
// lets local logic put all members back into reset without the group reset.
//
// Ports:
//   clock        - member clock, all logic on the rising edge
//   reset        - raw asynchronous active-high group reset
//   sw_reset_req - level request to re-enter reset
//   sw_reset_ack - level acknowledge, high while members are held for software
//   member_reset - per-domain active-high resets, bit i is member i
//   all_released - high once every member_reset bit is low
// ---------------------------------------------------------------------------
module clock_group_reset_sink
   import clock_group_pkg::*;
#(
   parameter int NUM_MEMBERS = DEF_NUM_MEMBERS,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int STRETCH     = DEF_STRETCH,
   parameter int STAGGER     = DEF_STAGGER
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   sw_reset_req,
   output logic                   sw_reset_ack,
   output logic [NUM_MEMBERS-1:0] member_reset,
   output logic                   all_released
);

   localparam int CNT_W = cnt_width(STRETCH, STAGGER);
   localparam int IDX_W = $clog2(NUM_MEMBERS + 1);

   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH - 1);
   localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER - 1);
   localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_MEMBERS - 1);

   logic              sync_rst;
   sink_state_t       state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx;

   reset_synchronizer #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clock    (clock),
      .reset    (reset),
      .sync_rst (sync_rst)
   );

   // Sequencer. The raw reset puts every output straight into its reset value
   // without waiting for a clock. After that the synchronized reset is waited
   // out, a stretch period is counted, and members are released one per
   // STAGGER cycles in ascending order. idx always names the next member to
   // release, so a member can never come out ahead of a lower-numbered one.
   // The software path drops every member back into reset at once, holds them
   // for STRETCH cycles, raises the acknowledge, and restarts the release
   // sequence when the request goes away. The counter restarts from zero on
   // every state entry, so it never needs to wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= ST_SYNC;
         cnt          <= '0;
         idx          <= '0;
         member_reset <= '1;
         all_released <= 1'b0;
         sw_reset_ack <= 1'b0;
      end else begin
         case (state)
            ST_SYNC: begin
               if (!sync_rst) begin
                  state <= ST_STRETCH;
                  cnt   <= '0;
               end
            end

            ST_STRETCH: begin
               if (cnt == STRETCH_LAST) begin
                  cnt             <= '0;
                  idx             <= IDX_W'(1);
                  member_reset[0] <= 1'b0;
                  if (NUM_MEMBERS == 1) begin
                     state        <= ST_RUN;
                     all_released <= 1'b1;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_RELEASE: begin
               if (cnt == STAGGER_LAST) begin
                  cnt <= '0;
                  idx <= idx + IDX_W'(1);
                  for (int i = 0; i < NUM_MEMBERS; i++) begin
                     if (idx == IDX_W'(i)) begin
                        member_reset[i] <= 1'b0;
                     end
                  end
                  if (idx == LAST_IDX) begin
                     state        <= ST_RUN;
                     all_released <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_RUN: begin
               if (sw_reset_req) begin
                  state        <= ST_SW_HOLD;
                  member_reset <= '1;
                  all_released <= 1'b0;
                  cnt          <= '0;
               end
            end

            ST_SW_HOLD: begin
               if (cnt == STRETCH_LAST) begin
                  state        <= ST_SW_WAIT;
                  sw_reset_ack <= 1'b1;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            ST_SW_WAIT: begin
               if (!sw_reset_req) begin
                  sw_reset_ack    <= 1'b0;
                  member_reset[0] <= 1'b0;
                  idx             <= IDX_W'(1);
                  cnt             <= '0;
                  if (NUM_MEMBERS == 1) begin
                     state        <= ST_RUN;
                     all_released <= 1'b1;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end
            end

            default: begin
               state <= ST_SYNC;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clock_group_reset_sink.sv
// ---------------------------------------------------------------------------
// tb_clock_group_reset_sink
// Drives two sinks from the same clock, reset and request: one with the
// default parameters and one with the smallest legal parameter set. Each is
// compared every cycle against a timeline model that predicts, from edge
// counts alone, when each member should come out of reset and when the
// software acknowledge should be high.
// ---------------------------------------------------------------------------
module tb_clock_group_reset_sink;

   logic       clock;
   logic       reset;
   logic       sw_reset_req;

   logic       ackA;
   logic [5:0] memberA;
   logic       allA;

   logic       ackB;
   logic [0:0] memberB;
   logic       allB;

   int testsRun;
   int testsFailed;

   // Model parameters, index 0 is the default sink, index 1 the corner sink
   int pMembers [2] = '{6, 1};
   int pSync    [2] = '{3, 2};
   int pStretch [2] = '{16, 1};
   int pStagger [2] = '{4, 1};

   // Model timeline: edgeCount counts rising edges since reset dropped.
   // relBase is the edge after which member 0 is released; member i follows
   // i*STAGGER edges later. holdStart is the edge where a software request
   // was taken.
   int edgeCount;
   int relBase   [2];
   int holdStart [2];
   bit inSw      [2];

   clock_group_reset_sink dutA (
      .clock        (clock),
      .reset        (reset),
      .sw_reset_req (sw_reset_req),
      .sw_reset_ack (ackA),
      .member_reset (memberA),
      .all_released (allA)
   );

   clock_group_reset_sink #(
      .NUM_MEMBERS (1),
      .SYNC_STAGES (2),
      .STRETCH     (1),
      .STAGGER     (1)
   ) dutB (
      .clock        (clock),
      .reset        (reset),
      .sw_reset_req (sw_reset_req),
      .sw_reset_ack (ackB),
      .member_reset (memberB),
      .all_released (allB)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag,
                  actual, expected, $time);
      end
   endtask

   function automatic logic [5:0] expMembers(input int k);
      logic [5:0] v;
      v = '0;
      for (int i = 0; i < pMembers[k]; i++) begin
         if (inSw[k]) v[i] = 1'b1;
         else         v[i] = (edgeCount < relBase[k] + i * pStagger[k]);
      end
      return v;
   endfunction

   function automatic logic expAll(input int k);
      return !inSw[k] &&
             (edgeCount >= relBase[k] + (pMembers[k] - 1) * pStagger[k]);
   endfunction

   function automatic logic expAck(input int k);
      return inSw[k] && (edgeCount >= holdStart[k] + pStretch[k]);
   endfunction

   // Timeline model. A software request is taken only once every member has
   // been out (strictly after the edge that released the last one), and
   // the request drop only counts once the hold period has elapsed.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         edgeCount <= 0;
         for (int k = 0; k < 2; k++) begin
            relBase[k]   <= pSync[k] + 1 + pStretch[k];
            holdStart[k] <= 0;
            inSw[k]      <= 1'b0;
         end
      end else begin
         edgeCount <= edgeCount + 1;
         for (int k = 0; k < 2; k++) begin
            if (!inSw[k]) begin
               if (sw_reset_req &&
                   (edgeCount + 1 > relBase[k] + (pMembers[k] - 1) * pStagger[k])) begin
                  inSw[k]      <= 1'b1;
                  holdStart[k] <= edgeCount + 1;
               end
            end else if (!sw_reset_req &&
                         (edgeCount + 1 > holdStart[k] + pStretch[k])) begin
               inSw[k]    <= 1'b0;
               relBase[k] <= edgeCount + 1;
            end
         end
      end
   end

   // Per-cycle comparison of both sinks against the model, away from the
   // active edge.
   always @(negedge clock) begin
      checkOutput("memberA", 32'(memberA), 32'(expMembers(0)));
      checkOutput("allA",    32'(allA),    32'(expAll(0)));
      checkOutput("ackA",    32'(ackA),    32'(expAck(0)));
      checkOutput("memberB", 32'(memberB), 32'(expMembers(1) & 6'h01));
      checkOutput("allB",    32'(allB),    32'(expAll(1)));
      checkOutput("ackB",    32'(ackB),    32'(expAck(1)));
   end

   // Holds the request at reqVal for the given number of cycles.
   task automatic applyStimulus(input logic reqVal, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         @(negedge clock);
         #1 sw_reset_req = reqVal;
      end
   endtask

   // Raises reset between edges and checks that outputs go to their reset
   // values straight away, with no clock edge involved.
   task automatic pulseReset(input string tag);
      @(negedge clock);
      #1 reset = 1'b1;
      #1;
      checkOutput({tag, "_memberA"}, 32'(memberA), 32'h3f);
      checkOutput({tag, "_allA"},    32'(allA),    32'h0);
      checkOutput({tag, "_ackA"},    32'(ackA),    32'h0);
      checkOutput({tag, "_memberB"}, 32'(memberB), 32'h1);
      #2 reset = 1'b0;
   endtask

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      reset        = 1'b1;
      sw_reset_req = 1'b0;

      // Power-on: reset held for a few cycles, then released between edges
      repeat (3) @(negedge clock);
      checkOutput("por_member", 32'(memberA), 32'h3f);
      #1 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1 checkOutput("corner_e3_member", 32'(memberB), 32'h1);
      checkOutput("corner_e3_all", 32'(allB), 32'h0);
      @(posedge clock);
      #1 checkOutput("corner_e4_member", 32'(memberB), 32'h0);
      checkOutput("corner_e4_all", 32'(allB), 32'h1);
      repeat (15) @(posedge clock);
      #1 checkOutput("e19_member", 32'(memberA), 32'h3f);
      @(posedge clock);
      #1 checkOutput("e20_member", 32'(memberA), 32'h3e);
      repeat (19) @(posedge clock);
      #1 checkOutput("e39_member", 32'(memberA), 32'h20);
      checkOutput("e39_all", 32'(allA), 32'h0);
      @(posedge clock);
      #1 checkOutput("e40_member", 32'(memberA), 32'h00);
      checkOutput("e40_all", 32'(allA), 32'h1);
      applyStimulus(1'b0, 3);

      // Software reset handshake from RUN
      @(negedge clock);
      #1 sw_reset_req = 1'b1;
      @(posedge clock);
      #1 checkOutput("sw_e_member", 32'(memberA), 32'h3f);
      checkOutput("sw_e_all", 32'(allA), 32'h0);
      repeat (15) @(posedge clock);
      #1 checkOutput("sw_e15_ack", 32'(ackA), 32'h0);
      @(posedge clock);
      #1 checkOutput("sw_e16_ack", 32'(ackA), 32'h1);
      applyStimulus(1'b1, 4);
      @(negedge clock);
      #1 sw_reset_req = 1'b0;
      @(posedge clock);
      #1 checkOutput("sw_f_ack", 32'(ackA), 32'h0);
      checkOutput("sw_f_member", 32'(memberA), 32'h3e);
      applyStimulus(1'b0, 30);

      // Glitch during the release sequence once member 2 is out
      pulseReset("rst0");
      applyStimulus(1'b0, 30);
      pulseReset("glitch");
      repeat (19) @(posedge clock);
      #1 checkOutput("glitch_e19_member", 32'(memberA), 32'h3f);
      @(posedge clock);
      #1 checkOutput("glitch_e20_member", 32'(memberA), 32'h3e);
      applyStimulus(1'b0, 25);

      // Early request held from power-on, then a reset while acknowledged
      sw_reset_req = 1'b1;
      pulseReset("early");
      applyStimulus(1'b1, 60);
      checkOutput("early_ack", 32'(ackA), 32'h1);
      pulseReset("swwait");
      checkOutput("swwait_ack", 32'(ackA), 32'h0);
      applyStimulus(1'b1, 45);
      applyStimulus(1'b0, 30);

      // Randomized request toggling with occasional reset pulses
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            pulseReset("rand");
         end else begin
            @(negedge clock);
            #1;
            if ($urandom_range(0, 7) == 0) sw_reset_req = ~sw_reset_req;
         end
      end

      repeat (2) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
